// File: rtl/bus_master_ctrl.sv
// bus_master_ctrl: if_bus master engine (req/gnt/start/rdy) with cmd/rsp handshakes and a WAIT timeout.
module bus_master_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       bus_req,
  output logic       bus_start,
  input  logic       bus_gnt,
  input  logic       bus_rdy,
  output logic [1:0] bus_mode,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_data_o,
  output logic       bus_data_oe,
  input  logic [7:0] bus_data_i
);
  typedef enum logic [1:0] {IDLE, REQ, START, WAIT} state_t;
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] wdata_q;
  logic tmo;
  assign cmd_ready = (state == IDLE) && !rsp_valid;
  assign bus_data_o = wdata_q;
  assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  // bus_mode[0] doubles as the registered write flag while a transaction is active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      wdata_q <= '0;
      bus_req <= 1'b0;
      bus_start <= 1'b0;
      bus_mode <= 2'b00;
      bus_addr <= '0;
      bus_data_oe <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          state <= REQ;
          bus_req <= 1'b1;
          bus_mode <= {1'b0, cmd_write};
          bus_addr <= cmd_addr;
          wdata_q <= cmd_wdata;
        end
        REQ: if (bus_gnt) begin
          state <= START;
          bus_start <= 1'b1;
          bus_data_oe <= bus_mode[0];
        end
        START: begin
          state <= WAIT;
          bus_start <= 1'b0;
          cnt <= '0;
        end
        WAIT: if (bus_rdy || tmo) begin
          state <= IDLE;
          bus_req <= 1'b0;
          bus_data_oe <= 1'b0;
          bus_mode <= 2'b00;
          bus_addr <= '0;
          rsp_valid <= 1'b1;
          rsp_err <= !bus_rdy;
          rsp_rdata <= (bus_rdy && !bus_mode[0]) ? bus_data_i : 8'h00;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_master_ctrl.sv
// tb_bus_master_ctrl: table-driven and randomized checks of bus_master_ctrl against a transaction-level model.
module tb_bus_master_ctrl;
  localparam int TO = 4;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [7:0] cmd_addr = 0, cmd_wdata = 0;
  logic rsp_valid, rsp_ready = 0, rsp_err;
  logic [7:0] rsp_rdata;
  logic bus_req, bus_start, bus_gnt = 0, bus_rdy = 0, bus_data_oe;
  logic [1:0] bus_mode;
  logic [7:0] bus_addr, bus_data_o, bus_data_i = 0;
  int checks = 0, failures = 0;
  bus_master_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_start(bus_start), .bus_gnt(bus_gnt), .bus_rdy(bus_rdy),
    .bus_mode(bus_mode), .bus_addr(bus_addr), .bus_data_o(bus_data_o),
    .bus_data_oe(bus_data_oe), .bus_data_i(bus_data_i)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit wr; bit [7:0] addr, wdata, din; int g, r, hold; bit sn;
    int lat; bit err; bit [7:0] rdata;
  } vec_t;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask
  // g = REQ cycles before gnt, r = WAIT cycles before rdy; the response lands
  // either on the rdy cycle or after TO WAIT cycles, whichever comes first
  function automatic vec_t model(input vec_t v);
    vec_t m = v;
    m.err = v.r >= TO;
    m.lat = m.err ? 2 + v.g + TO : 3 + v.g + v.r;
    m.rdata = (m.err || v.wr) ? 8'h00 : v.din;
    return m;
  endfunction
  task automatic run(input vec_t v, input string tag);
    int n, starts, reqs, oes, bad, lat, wc;
    @(negedge clk);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, n < 50, 1);
    if (n >= 50) begin cmd_valid = 0; return; end
    @(posedge clk);
    #1 cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
    starts = 0; reqs = 0; oes = 0; bad = 0; lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = i; break; end
      if (!bus_req || bus_mode !== {1'b0, v.wr} || bus_addr !== v.addr) bad++;
      if (bus_start) starts++;
      if (starts == 0) reqs++;
      if (bus_data_oe) begin oes++; if (bus_data_o !== v.wdata) bad++; end
      bus_gnt = (i == v.g) || (i > v.g && $urandom_range(1) == 1);
      bus_rdy = (i == v.g + 2 + v.r) || (i == v.g + 1 && v.sn);
      bus_data_i = (i == v.g + 2 + v.r) ? v.din : 8'($urandom);
    end
    bus_gnt = 0; bus_rdy = 0;
    wc = (v.r < TO) ? v.r + 1 : TO;
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_start_pulses"}, starts, 1);
    chk({tag, "_req_before_start"}, reqs, v.g + 1);
    chk({tag, "_oe_cycles"}, oes, v.wr ? wc + 1 : 0);
    chk({tag, "_bus_fields"}, bad, 0);
    chk({tag, "_rdata"}, rsp_rdata, v.rdata);
    chk({tag, "_err"}, rsp_err, v.err);
    chk({tag, "_idle_bus"}, {cmd_ready, bus_req, bus_data_oe, bus_mode, bus_addr}, 0);
    bad = 0;
    cmd_valid = 1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || rsp_rdata !== v.rdata || rsp_err !== v.err) bad++;
    end
    chk({tag, "_hold_stable"}, bad, 0);
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0; cmd_valid = 0;
    chk({tag, "_consumed"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask
  vec_t tbl [7];
  vec_t v;
  int bad;
  initial begin
    //           wr addr   wdata  din    g  r   hold sn lat err rdata
    tbl[0] = '{0, 8'h3C, 8'h00, 8'hA5, 0, 0,  0, 0, 3,  0, 8'hA5};
    tbl[1] = '{1, 8'h10, 8'h5A, 8'hFF, 5, 1,  0, 0, 9,  0, 8'h00};
    tbl[2] = '{0, 8'h20, 8'h00, 8'h77, 0, 99, 0, 0, 6,  1, 8'h00};
    tbl[3] = '{1, 8'hC3, 8'h81, 8'h11, 2, 99, 1, 0, 8,  1, 8'h00};
    tbl[4] = '{0, 8'h44, 8'h00, 8'h3C, 1, 2,  3, 0, 6,  0, 8'h3C};
    tbl[5] = '{0, 8'h55, 8'h00, 8'h9E, 0, 3,  0, 0, 6,  0, 8'h9E};
    tbl[6] = '{0, 8'h66, 8'h00, 8'hD2, 0, 0,  1, 1, 3,  0, 8'hD2};
    #2;
    chk("reset_outputs", {bus_req, bus_start, bus_mode, bus_addr, bus_data_o, bus_data_oe,
                          rsp_valid, rsp_rdata, rsp_err}, 0);
    @(negedge clk); rst_n = 1;
    #1 chk("reset_cmd_ready", cmd_ready, 1);
    foreach (tbl[k]) run(tbl[k], $sformatf("vec%0d", k));
    // asynchronous reset while a write sits in WAIT
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h2E; cmd_wdata = 8'hB4;
    @(posedge clk);
    #1 cmd_valid = 0;
    @(negedge clk); bus_gnt = 1;
    @(negedge clk); bus_gnt = 0;
    @(negedge clk);
    chk("rst_pre_wait", {bus_req, bus_data_oe, bus_start}, 3'b110);
    #1 rst_n = 0;
    #1 chk("rst_async_release", {bus_req, bus_data_oe, rsp_valid, bus_start}, 0);
    @(negedge clk); rst_n = 1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_rdy = (i < 3);
      if (rsp_valid || bus_req || !cmd_ready) bad++;
    end
    bus_rdy = 0;
    chk("rst_no_response", bad, 0);
    for (int k = 0; k < 40; k++) begin
      v.wr = 1'($urandom); v.addr = 8'($urandom); v.wdata = 8'($urandom); v.din = 8'($urandom);
      v.g = $urandom_range(6); v.r = $urandom_range(7); v.hold = $urandom_range(2);
      v.sn = 1'($urandom);
      run(model(v), $sformatf("rnd%0d", k));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
